if_id_stage_reg: RTL and testbench
==================================

Name: if_id_stage_reg

Overview:
Parametrised IF/ID pipeline stage register for the pipelined processor. It latches PC and IR from fetch and presents them to decode. It adds a valid/ready handshake, a 2-entry skid buffer for decode back-pressure, and a synchronous flush for branch redirects. Data is never lost or duplicated while decode stalls.

Parameters:
PC_W, 32, width of program counter field
IR_W, 32, width of instruction field
RESET_PC, 32'h0000_0000, out_pc value after reset
NOP_INSTR, 32'h0000_0000, out_ir value after reset and after flush (bubble)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
flush  in  1  synchronous squash of all held entries (branch/jump redirect)
in_valid  in  1  fetch presents a valid PC/IR
in_ready  out  1  stage can accept; registered, not combinational from out_ready
in_pc  in  PC_W  fetched PC
in_ir  in  IR_W  fetched instruction
out_valid  out  1  decode-side entry valid
out_ready  in  1  decode accepts the entry this cycle
out_pc  out  PC_W  PC to decode
out_ir  out  IR_W  instruction to decode

Behaviour:
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Storage: main entry (drives out_*), skid entry (holds one overflow item).
- States: EMPTY (main invalid), BUSY (main valid, skid empty), FULL (main and skid valid).
- Outputs: out_valid = (state != EMPTY); in_ready = (state != FULL), both decoded from registered state.
- Transitions:
  - EMPTY: in_fire -> BUSY, main <= in.
  - BUSY: in_fire & !out_fire -> FULL, skid <= in.
  - BUSY: in_fire & out_fire -> BUSY, main <= in.
  - BUSY: !in_fire & out_fire -> EMPTY.
  - BUSY: neither -> hold.
  - FULL: out_fire -> BUSY, main <= skid; otherwise hold. No input is accepted in FULL.
- Latency: 1 cycle from in_fire in EMPTY to out_valid=1 with the same PC/IR.
- Order: strict FIFO. The skid entry always drains to main before any new input.
- Hold: while out_valid & !out_ready, out_pc/out_ir are stable cycle to cycle.
- Flush: next state EMPTY; out_ir <= NOP_INSTR; out_pc holds. Flush overrides in_fire and out_fire in the same cycle, and the input offered that cycle is dropped. Flush in FULL discards both entries.
- Reset (async, any state, mid-transfer included): state EMPTY, out_valid=0, in_ready=1, out_pc=RESET_PC, out_ir=NOP_INSTR, skid contents don't-care. The first rising edge after deassertion behaves as in EMPTY.
- When out_valid=0, out_pc/out_ir hold their last value; decode must ignore them.

Optional Feature:
Macro IF_ID_STALL_CNT_EN.
- Defined:
  - Adds output stall_count [15:0]: counts cycles with out_valid & !out_ready.
  - Saturates at 16'hFFFF.
  - Cleared by rst only, not by flush.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset then single transfer: rst pulse; in_valid=1, in_pc=0x100, in_ir=0x8C220004, out_ready=1 for one cycle -> next cycle out_valid=1, out_pc=0x100, out_ir=0x8C220004; the cycle after, out_valid=0.
- Streaming: PCs 0x0,0x4,0x8,0xC on consecutive cycles, out_ready=1 throughout -> same sequence on out_* one cycle later; in_ready stays 1.
- Back-pressure/skid: out_ready=0, send 0x10 then 0x14 -> in_ready=0 after the second; out_pc stays 0x10 across 5 stalled cycles. Then out_ready=1 -> 0x10, then 0x14, delivered once each; in_ready returns to 1.
- Flush in FULL with simultaneous input: entries 0x20/0x24 held, flush=1 with in_valid=1, in_pc=0x28 -> next cycle out_valid=0, out_ir=NOP_INSTR; 0x28 never appears at the output.
- Async reset mid-stall: FULL state, assert rst between clock edges -> out_valid=0, in_ready=1, out_pc=RESET_PC immediately without a clock edge.
- IF_ID_STALL_CNT_EN: hold out_ready=0 for 10 cycles with a valid entry -> stall_count=10. Then flush -> stall_count remains 10.

Source files
------------

// File: rtl/if_id_stage_reg.sv
// IF/ID pipeline register: valid/ready handshake, 2-entry skid buffer, synchronous flush.
// Optional stall-cycle counter output enabled by defining IF_ID_STALL_CNT_EN.
module if_id_stage_reg #(
  parameter int              PC_W      = 32,
  parameter int              IR_W      = 32,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter logic [IR_W-1:0] NOP_INSTR = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [PC_W-1:0] in_pc,
  input  logic [IR_W-1:0] in_ir,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [PC_W-1:0] out_pc,
  output logic [IR_W-1:0] out_ir,
`ifdef IF_ID_STALL_CNT_EN
  output logic [15:0]     stall_count,
`endif
  output logic [1:0]      dbg_state
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [PC_W-1:0] r_main_pc;
  logic [IR_W-1:0] r_main_ir;
  logic [PC_W-1:0] r_skid_pc;
  logic [IR_W-1:0] r_skid_ir;

  logic w_in_fire;
  logic w_out_fire;
  logic w_load_main_in;
  logic w_load_main_skid;
  logic w_load_skid;
  logic w_clear_ir;

  // Handshake: a transfer happens on a rising edge where valid & ready are both
  // high; ready is decoded from registered state only, never from out_ready.
  assign in_ready   = (r_state != ST_FULL);
  assign out_valid  = (r_state != ST_EMPTY);
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;
  assign out_pc     = r_main_pc;
  assign out_ir     = r_main_ir;
  assign dbg_state  = r_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state     = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    w_clear_ir       = 1'b0;
    if (flush) begin
      // Redirect wins over both handshakes; the offered input is dropped.
      w_next_state = ST_EMPTY;
      w_clear_ir   = 1'b1;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_fire) begin
            w_next_state   = ST_BUSY;
            w_load_main_in = 1'b1;
          end
        end
        ST_BUSY: begin
          if (w_in_fire && w_out_fire) begin
            w_load_main_in = 1'b1;
          end else if (w_in_fire) begin
            w_next_state = ST_FULL;
            w_load_skid  = 1'b1;
          end else if (w_out_fire) begin
            w_next_state = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (w_out_fire) begin
            w_next_state     = ST_BUSY;
            w_load_main_skid = 1'b1;
          end
        end
        default: begin
          w_next_state = ST_EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_main_pc <= RESET_PC;
      r_main_ir <= NOP_INSTR;
      r_skid_pc <= '0;
      r_skid_ir <= '0;
    end else begin
      if (w_clear_ir) begin
        r_main_ir <= NOP_INSTR;
      end else if (w_load_main_in) begin
        r_main_pc <= in_pc;
        r_main_ir <= in_ir;
      end else if (w_load_main_skid) begin
        r_main_pc <= r_skid_pc;
        r_main_ir <= r_skid_ir;
      end
      if (w_load_skid) begin
        r_skid_pc <= in_pc;
        r_skid_ir <= in_ir;
      end
    end
  end

`ifdef IF_ID_STALL_CNT_EN
  logic [15:0] r_stall_count;

  // Saturating; flush deliberately leaves it alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_count <= '0;
    end else if (out_valid && !out_ready && (r_stall_count != 16'hFFFF)) begin
      r_stall_count <= r_stall_count + 16'd1;
    end
  end

  assign stall_count = r_stall_count;
`endif

endmodule

// File: tb/tb_if_id_stage_reg.sv
// Directed + random bench for if_id_stage_reg with an occupancy model and an expected queue.
module tb_if_id_stage_reg;

  localparam logic [31:0] RST_PC = 32'hFFFF_FFF0;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_ir;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_ir;
  logic [1:0]  dbg_state;
`ifdef IF_ID_STALL_CNT_EN
  logic [15:0] stall_count;
`endif

  if_id_stage_reg #(
    .PC_W      (32),
    .IR_W      (32),
    .RESET_PC  (RST_PC),
    .NOP_INSTR (NOP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_pc       (in_pc),
    .in_ir       (in_ir),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_ir      (out_ir),
`ifdef IF_ID_STALL_CNT_EN
    .stall_count (stall_count),
`endif
    .dbg_state   (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // scoreboard state
  logic [63:0] exp_q[$];
  logic [31:0] hold_pc;
  logic [31:0] hold_ir;
  int          m_cnt;
  logic [15:0] m_stall;
  int          checks;
  int          errors;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_cnt   = 0;
    hold_pc = RST_PC;
    hold_ir = NOP;
    m_stall = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'(1'b0));
    chk({tag, "_in_ready"},  64'(in_ready),  64'(1'b1));
    chk({tag, "_out_pc"},    64'(out_pc),    64'(RST_PC));
    chk({tag, "_out_ir"},    64'(out_ir),    64'(NOP));
`ifdef IF_ID_STALL_CNT_EN
    chk({tag, "_stall_count"}, 64'(stall_count), 64'(16'd0));
`endif
  endtask

  // driver: called just after an edge; checks the present outputs, then advances one cycle
  task automatic cycle(input logic v, input logic [31:0] pc, input logic [31:0] ir,
                       input logic rdy, input logic fl);
    logic [63:0] shown;
    logic        acc;
    logic        pop;
    in_valid  = v;
    in_pc     = pc;
    in_ir     = ir;
    out_ready = rdy;
    flush     = fl;
    shown = (m_cnt > 0) ? exp_q[0] : {hold_pc, hold_ir};
    chk("in_ready",  64'(in_ready),  64'(m_cnt < 2));
    chk("out_valid", 64'(out_valid), 64'(m_cnt > 0));
    chk("out_pc",    64'(out_pc),    64'(shown[63:32]));
    chk("out_ir",    64'(out_ir),    64'(shown[31:0]));
`ifdef IF_ID_STALL_CNT_EN
    chk("stall_count", 64'(stall_count), 64'(m_stall));
`endif
    acc = v && (m_cnt < 2);
    pop = (m_cnt > 0) && rdy;
    if ((m_cnt > 0) && !rdy && (m_stall != 16'hFFFF)) m_stall = m_stall + 16'd1;
    @(posedge clk);
    #1;
    if (fl) begin
      exp_q.delete();
      hold_pc = shown[63:32];
      hold_ir = NOP;
    end else begin
      if (pop) void'(exp_q.pop_front());
      if (acc) exp_q.push_back({pc, ir});
      if (exp_q.size() == 0) {hold_pc, hold_ir} = shown;
    end
    m_cnt = exp_q.size();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_pc     = '0;
    in_ir     = '0;
    out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    // single transfer: visible one cycle later, gone the cycle after
    cycle(1'b1, 32'h100, 32'h8C22_0004, 1'b1, 1'b0);
    idle(3);

    // streaming at full rate
    for (int i = 0; i < 4; i++) cycle(1'b1, 32'(i * 4), $urandom, 1'b1, 1'b0);
    idle(2);

    // back-pressure into the skid, a third offer refused while FULL, then drain
    cycle(1'b1, 32'h10, 32'hA000_0010, 1'b0, 1'b0);
    cycle(1'b1, 32'h14, 32'hA000_0014, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b1, 32'h18, 32'hA000_0018, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b1, 32'h18, 32'hA000_0018, 1'b1, 1'b0);
    idle(2);

    // flush in FULL with an input offered the same cycle
    cycle(1'b1, 32'h20, 32'hB000_0020, 1'b0, 1'b0);
    cycle(1'b1, 32'h24, 32'hB000_0024, 1'b0, 1'b0);
    cycle(1'b1, 32'h28, 32'hB000_0028, 1'b1, 1'b1);
    idle(3);

    // flush in BUSY with simultaneous in/out fire
    cycle(1'b1, 32'h40, 32'hC000_0040, 1'b1, 1'b0);
    cycle(1'b1, 32'h44, 32'hC000_0044, 1'b1, 1'b1);
    idle(2);

    // stall accounting: ten stalled cycles with a valid entry, then flush
    cycle(1'b1, 32'h30, 32'hD000_0030, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    idle(2);

    // random traffic with occasional flushes
    for (int i = 0; i < 200; i++)
      cycle(1'($urandom_range(0, 1)), $urandom, $urandom,
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
    idle(3);

    // async reset between edges while FULL
    cycle(1'b1, 32'h50, 32'hE000_0050, 1'b0, 1'b0);
    cycle(1'b1, 32'h54, 32'hE000_0054, 1'b0, 1'b0);
    cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    in_valid = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycle(1'b1, 32'h60, 32'hF000_0060, 1'b1, 1'b0);
    idle(2);

    chk("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
